// File: rtl/blast_map_writer.sv
// Explosion resolver: walks the four blast arms outward from the bomb tile,
// clears bricks in the tile-map RAM and reports every burning tile.
module blast_map_writer #(
  parameter int         MAP_W      = 40,
  parameter int         MAP_H      = 40,
  parameter logic [7:0] FLOOR_CODE = 8'd10,
  parameter logic [7:0] BRICK_CODE = 8'd9,
  parameter logic [7:0] WALL_CODE  = 8'd11,
  parameter int         RANGE_W    = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               blast_valid,
  output logic               blast_ready,
  input  logic [5:0]         blast_x,
  input  logic [5:0]         blast_y,
  input  logic [RANGE_W-1:0] blast_range,
  output logic [5:0]         map_rd_x,
  output logic [5:0]         map_rd_y,
  input  logic [7:0]         map_rd_data,
  output logic               map_we,
  output logic [5:0]         map_wr_x,
  output logic [5:0]         map_wr_y,
  output logic [7:0]         map_wr_data,
  output logic               flame_valid,
  output logic [5:0]         flame_x,
  output logic [5:0]         flame_y,
  output logic               done,
  output logic [2:0]         bricks_cleared,
  output logic [15:0]        bricks_total
);

  typedef enum logic [2:0] {S_IDLE, S_CENTER, S_STEP, S_READ, S_EVAL, S_DONE} state_t;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  localparam logic signed [6:0] LP_W = 7'(MAP_W);
  localparam logic signed [6:0] LP_H = 7'(MAP_H);

  state_t             r_state;
  dir_t               r_dir;
  logic [RANGE_W-1:0] r_k;
  logic [RANGE_W-1:0] r_range;
  logic [5:0]         r_bx, r_by;
  logic [5:0]         r_cx, r_cy;
  logic [2:0]         r_cnt;

  logic signed [6:0]  w_nx, w_ny;
  logic               w_oob, w_is_wall, w_is_brick, w_end_arm;

  assign map_wr_data = FLOOR_CODE;

  // Next arm tile in 7-bit signed space so a step off either edge is detectable.
  always_comb begin
    w_nx = $signed({1'b0, r_cx});
    w_ny = $signed({1'b0, r_cy});
    unique case (r_dir)
      D_UP:    w_ny = $signed({1'b0, r_cy}) - 7'sd1;
      D_DOWN:  w_ny = $signed({1'b0, r_cy}) + 7'sd1;
      D_LEFT:  w_nx = $signed({1'b0, r_cx}) - 7'sd1;
      D_RIGHT: w_nx = $signed({1'b0, r_cx}) + 7'sd1;
    endcase
    w_oob      = (w_nx < 7'sd0) || (w_nx >= LP_W) || (w_ny < 7'sd0) || (w_ny >= LP_H);
    w_is_wall  = (map_rd_data == WALL_CODE);
    w_is_brick = (map_rd_data == BRICK_CODE);
    w_end_arm  = ((r_state == S_STEP) && ((r_k == r_range) || w_oob)) ||
                 ((r_state == S_EVAL) && (w_is_wall || w_is_brick));
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state        <= S_IDLE;
      r_dir          <= D_UP;
      r_k            <= '0;
      r_range        <= '0;
      r_bx           <= '0;
      r_by           <= '0;
      r_cx           <= '0;
      r_cy           <= '0;
      r_cnt          <= '0;
      blast_ready    <= 1'b1;
      map_rd_x       <= '0;
      map_rd_y       <= '0;
      map_we         <= 1'b0;
      map_wr_x       <= '0;
      map_wr_y       <= '0;
      flame_valid    <= 1'b0;
      flame_x        <= '0;
      flame_y        <= '0;
      done           <= 1'b0;
      bricks_cleared <= '0;
      bricks_total   <= '0;
    end else begin
      flame_valid <= 1'b0;
      map_we      <= 1'b0;
      done        <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (blast_valid) begin
            r_bx        <= blast_x;
            r_by        <= blast_y;
            r_cx        <= blast_x;
            r_cy        <= blast_y;
            r_range     <= blast_range;
            r_dir       <= D_UP;
            r_k         <= '0;
            r_cnt       <= '0;
            blast_ready <= 1'b0;
            flame_valid <= 1'b1;
            flame_x     <= blast_x;
            flame_y     <= blast_y;
            r_state     <= S_CENTER;
          end
        end
        S_CENTER: r_state <= S_STEP;
        S_STEP: begin
          if (!w_end_arm) begin
            r_k      <= r_k + RANGE_W'(1);
            r_cx     <= w_nx[5:0];
            r_cy     <= w_ny[5:0];
            map_rd_x <= w_nx[5:0];
            map_rd_y <= w_ny[5:0];
            r_state  <= S_READ;
          end
        end
        S_READ: r_state <= S_EVAL;
        S_EVAL: begin
          if (!w_is_wall) begin
            flame_valid <= 1'b1;
            flame_x     <= r_cx;
            flame_y     <= r_cy;
          end
          if (w_is_brick) begin
            map_we   <= 1'b1;
            map_wr_x <= r_cx;
            map_wr_y <= r_cy;
            r_cnt    <= r_cnt + 3'd1;
          end
          if (!w_end_arm) r_state <= S_STEP;
        end
        S_DONE: begin
          done           <= 1'b1;
          bricks_cleared <= r_cnt;
          bricks_total   <= bricks_total + {13'd0, r_cnt};
          blast_ready    <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Arm termination from STEP (range/bounds) or EVAL (wall/brick) shares one path.
      if (w_end_arm) begin
        r_cx    <= r_bx;
        r_cy    <= r_by;
        r_k     <= '0;
        r_dir   <= dir_t'(r_dir + 2'd1);
        r_state <= (r_dir == D_RIGHT) ? S_DONE : S_STEP;
      end
    end
  end

endmodule

// File: tb/tb_blast_map_writer.sv
// Scoreboard bench for blast_map_writer: a tile-walk reference model fills
// expectation queues, a negedge monitor pops them as the DUT reports.
module tb_blast_map_writer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset_n = 1'b0;
  logic       blast_valid = 1'b0;
  logic       blast_ready;
  logic [5:0] blast_x = '0, blast_y = '0;
  logic [3:0] blast_range = '0;
  logic [5:0] map_rd_x, map_rd_y;
  logic [7:0] map_rd_data;
  logic       map_we;
  logic [5:0] map_wr_x, map_wr_y;
  logic [7:0] map_wr_data;
  logic       flame_valid;
  logic [5:0] flame_x, flame_y;
  logic       done;
  logic [2:0] bricks_cleared;
  logic [15:0] bricks_total;

  blast_map_writer #(
    .MAP_W(40), .MAP_H(40), .FLOOR_CODE(8'd10), .BRICK_CODE(8'd9),
    .WALL_CODE(8'd11), .RANGE_W(4)
  ) dut (
    .Clk(clk), .Reset_n(Reset_n), .blast_valid(blast_valid), .blast_ready(blast_ready),
    .blast_x(blast_x), .blast_y(blast_y), .blast_range(blast_range),
    .map_rd_x(map_rd_x), .map_rd_y(map_rd_y), .map_rd_data(map_rd_data),
    .map_we(map_we), .map_wr_x(map_wr_x), .map_wr_y(map_wr_y), .map_wr_data(map_wr_data),
    .flame_valid(flame_valid), .flame_x(flame_x), .flame_y(flame_y),
    .done(done), .bricks_cleared(bricks_cleared), .bricks_total(bricks_total)
  );

  // Tile RAM with 1-cycle read latency; tb_clr/tb_poke let the bench build maps.
  logic [7:0]  mem [0:1599];
  logic        tb_clr = 1'b0, tb_poke = 1'b0;
  int unsigned tb_idx = 0;
  logic [7:0]  tb_val = '0;

  always @(posedge clk) begin
    if (map_rd_x < 6'd40 && map_rd_y < 6'd40)
      map_rd_data <= mem[int'(map_rd_y) * 40 + int'(map_rd_x)];
    else
      map_rd_data <= 8'hFF;
    if (tb_clr) begin
      for (int i = 0; i < 1600; i++) mem[i] <= 8'd10;
    end else if (tb_poke) begin
      mem[tb_idx] <= tb_val;
    end
    if (map_we && map_wr_x < 6'd40 && map_wr_y < 6'd40)
      mem[int'(map_wr_y) * 40 + int'(map_wr_x)] <= map_wr_data;
  end

  typedef struct packed { logic [5:0] x; logic [5:0] y; } xy_t;
  typedef struct { int unsigned cleared; int unsigned total; int unsigned at; } done_t;

  xy_t         exp_flame[$];
  xy_t         exp_wr[$];
  done_t       exp_done[$];
  logic [7:0]  ref_map [0:1599];
  int unsigned model_total = 0;
  int unsigned cyc = 0;
  int unsigned n_vec = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: step each arm tile by tile over ref_map, accumulating cost.
  task automatic model_blast(input int bx, input int by, input int rng,
                             output int unsigned lat, output int unsigned cnt);
    int dx[4] = '{0, 0, -1, 1};
    int dy[4] = '{-1, 1, 0, 0};
    int nx, ny;
    bit stopped;
    lat = 2;
    cnt = 0;
    exp_flame.push_back(xy_t'{6'(bx), 6'(by)});
    for (int d = 0; d < 4; d++) begin
      stopped = 1'b0;
      for (int k = 1; k <= rng && !stopped; k++) begin
        nx = bx + dx[d] * k;
        ny = by + dy[d] * k;
        if (nx < 0 || nx >= 40 || ny < 0 || ny >= 40) begin
          lat += 1;
          stopped = 1'b1;
        end else begin
          lat += 3;
          if (ref_map[ny * 40 + nx] == 8'd11) begin
            stopped = 1'b1;
          end else if (ref_map[ny * 40 + nx] == 8'd9) begin
            exp_flame.push_back(xy_t'{6'(nx), 6'(ny)});
            exp_wr.push_back(xy_t'{6'(nx), 6'(ny)});
            ref_map[ny * 40 + nx] = 8'd10;
            cnt++;
            stopped = 1'b1;
          end else begin
            exp_flame.push_back(xy_t'{6'(nx), 6'(ny)});
          end
        end
      end
      if (!stopped) lat += 1;
    end
    model_total = (model_total + cnt) % 65536;
  endtask

  xy_t   m_xy;
  done_t m_d;
  always @(negedge clk) begin
    if (flame_valid) begin
      if (exp_flame.size() == 0) fail_now("flame_unexpected");
      else begin
        m_xy = exp_flame.pop_front();
        check("flame_xy", {20'd0, flame_x, flame_y}, {20'd0, m_xy});
      end
    end
    if (map_we) begin
      if (exp_wr.size() == 0) fail_now("write_unexpected");
      else begin
        m_xy = exp_wr.pop_front();
        check("write_xy", {20'd0, map_wr_x, map_wr_y}, {20'd0, m_xy});
        check("write_data", {24'd0, map_wr_data}, 32'd10);
      end
    end
    if (done) begin
      if (exp_done.size() == 0) fail_now("done_unexpected");
      else begin
        m_d = exp_done.pop_front();
        check("bricks_cleared", {29'd0, bricks_cleared}, m_d.cleared);
        check("bricks_total", {16'd0, bricks_total}, m_d.total);
        check("done_cycle", cyc, m_d.at);
      end
    end
    if (map_rd_x >= 6'd40 || map_rd_y >= 6'd40) fail_now("read_out_of_range");
  end

  task automatic map_clear();
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
    for (int i = 0; i < 1600; i++) ref_map[i] = 8'd10;
  endtask

  task automatic map_poke(input int x, input int y, input logic [7:0] v);
    tb_poke = 1'b1;
    tb_idx  = 32'(y * 40 + x);
    tb_val  = v;
    @(negedge clk);
    tb_poke = 1'b0;
    ref_map[y * 40 + x] = v;
  endtask

  task automatic check_map(input string name);
    int bad = 0;
    for (int i = 0; i < 1600; i++) if (mem[i] !== ref_map[i]) bad++;
    check(name, bad, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, blast_ready}, 32'd1);
    check({tag, "_strobes"}, {29'd0, flame_valid, map_we, done}, 32'd0);
    check({tag, "_flame_rd_xy"}, {8'd0, flame_x, flame_y, map_rd_x, map_rd_y}, 32'd0);
    check({tag, "_wr_xy_counts"}, {1'b0, map_wr_x, map_wr_y, bricks_cleared, bricks_total}, 32'd0);
  endtask

  // Issue one blast; blast_valid stays high a few cycles and the inputs are
  // scrambled after acceptance to confirm they were latched and re-requests ignored.
  task automatic run_blast(input int x, input int y, input int r);
    int unsigned lat, cnt, c;
    bit seen;
    model_blast(x, y, r, lat, cnt);
    c = cyc;
    exp_done.push_back(done_t'{cnt, model_total, c + 1 + lat});
    blast_x = 6'(x);
    blast_y = 6'(y);
    blast_range = 4'(r);
    blast_valid = 1'b1;
    @(negedge clk);
    check("busy_ready", {31'd0, blast_ready}, 32'd0);
    blast_x = 6'($urandom_range(0, 39));
    blast_y = 6'($urandom_range(0, 39));
    blast_range = 4'($urandom_range(0, 15));
    repeat ($urandom_range(0, 3)) @(negedge clk);
    blast_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) fail_now("done_timeout");
    @(negedge clk);
    check("flames_left", exp_flame.size(), 0);
    check("writes_left", exp_wr.size(), 0);
    check("dones_left", exp_done.size(), 0);
    check_map("map_contents");
  endtask

  initial begin
    int unsigned lat, cnt;
    bit seen;
    int bx, by, px, py;
    logic [7:0] codes [4];
    codes[0] = 8'd9; codes[1] = 8'd11; codes[2] = 8'd3; codes[3] = 8'd10;

    tb_clr = 1'b1;
    repeat (3) @(negedge clk);
    tb_clr = 1'b0;
    for (int i = 0; i < 1600; i++) ref_map[i] = 8'd10;
    check_idle_outputs("reset");
    Reset_n = 1'b1;
    @(negedge clk);

    // All floor, range 2: nine flames, done 30 cycles after accept.
    run_blast(5, 5, 2);

    // Bricks up/right, wall down.
    map_clear();
    map_poke(5, 3, 8'd9);
    map_poke(7, 5, 8'd9);
    map_poke(5, 6, 8'd11);
    run_blast(5, 5, 3);

    // Corner and far-corner range 0.
    map_clear();
    run_blast(0, 0, 3);
    run_blast(39, 39, 0);

    // Reset the cycle after a brick write; the write must survive.
    map_clear();
    map_poke(5, 4, 8'd9);
    model_blast(5, 5, 3, lat, cnt);
    blast_x = 6'd5; blast_y = 6'd5; blast_range = 4'd3; blast_valid = 1'b1;
    @(negedge clk);
    blast_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (map_we) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) fail_now("brick_write_timeout");
    Reset_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    exp_flame.delete();
    exp_wr.delete();
    exp_done.delete();
    model_total = 0;
    Reset_n = 1'b1;
    @(negedge clk);
    check_map("map_after_reset");
    check_idle_outputs("post_reset");

    // Fresh blast after reset.
    map_poke(8, 5, 8'd9);
    run_blast(5, 5, 4);

    // Randomized maps clustered around the bomb, with edge-biased positions.
    for (int t = 0; t < 14; t++) begin
      map_clear();
      bx = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 39) : int'($urandom_range(0, 39));
      by = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 39) : int'($urandom_range(0, 39));
      for (int p = 0; p < 20; p++) begin
        px = bx + int'($urandom_range(0, 16)) - 8;
        py = by + int'($urandom_range(0, 16)) - 8;
        if ($urandom_range(0, 1) == 0) px = bx; else py = by;
        if (px >= 0 && px < 40 && py >= 0 && py < 40 && !(px == bx && py == by))
          map_poke(px, py, codes[$urandom_range(0, 3)]);
      end
      run_blast(bx, by, int'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule

// File: doc/blast_map_writer.md
Name: blast_map_writer

Overview:
- Explosion resolver and write-side client of the 40x40 tile-index map RAM (8-bit codes: 10 = floor, 9 = destructible brick).
- Given a bomb position and blast range, it walks the four arms outward and reads each tile.
- Bricks are rewritten to floor, each flamed tile is reported for player/enemy kill logic, and a done pulse is raised with a brick count.
- Sits between bomb timer logic and the map RAM; the renderer reads the same RAM on the other port.

Parameters:
- MAP_W, 40, map columns (x range 0..MAP_W-1)
- MAP_H, 40, map rows (y range 0..MAP_H-1)
- FLOOR_CODE, 8'd10, passable tile code
- BRICK_CODE, 8'd9, destructible tile code
- WALL_CODE, 8'd11, indestructible tile code
- RANGE_W, 4, blast range width (max range 15)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  synchronous, active-low reset
- blast_valid  in  1  explosion request
- blast_ready  out  1  block idle, accepts request
- blast_x  in  6  bomb column
- blast_y  in  6  bomb row
- blast_range  in  RANGE_W  arm length in tiles
- map_rd_x  out  6  map read column
- map_rd_y  out  6  map read row
- map_rd_data  in  8  tile code; 1-cycle synchronous RAM latency
- map_we  out  1  map write strobe
- map_wr_x  out  6  write column
- map_wr_y  out  6  write row
- map_wr_data  out  8  write code (always FLOOR_CODE)
- flame_valid  out  1  one-cycle pulse: tile (flame_x, flame_y) is burning
- flame_x  out  6  flamed column
- flame_y  out  6  flamed row
- done  out  1  one-cycle pulse: blast resolved
- bricks_cleared  out  3  bricks destroyed by the last blast (0..4), valid with done, held until the next done
- bricks_total  out  16  running brick count, wraps at 2^16

Behaviour:
- Reset (Reset_n low at a Clk edge), from any state including mid-blast:
  - state IDLE; blast_ready=1.
  - map_we, flame_valid, done = 0.
  - All coordinate outputs, bricks_cleared and bricks_total = 0.
  - An in-progress blast is abandoned; writes already issued remain.
- States: IDLE, CENTER, STEP, READ, EVAL, DONE.
- IDLE:
  - blast_ready=1.
  - On blast_valid&&blast_ready, latch x/y/range, set direction=UP, clear arm step k and per-blast count, then go to CENTER.
  - blast_valid while not IDLE is ignored; there is no queue.
- CENTER (1 cycle):
  - flame_valid=1 at (blast_x, blast_y).
  - The center tile is neither read nor written.
  - Go to STEP.
- STEP (1 cycle):
  - Direction order: UP (y-1), DOWN (y+1), LEFT (x-1), RIGHT (x+1).
  - If k==range, or the next coordinate leaves 0..MAP_W-1 / 0..MAP_H-1, the arm ends. Advance direction and reset k. After RIGHT, go to DONE; otherwise stay in STEP.
  - Otherwise k++ and compute the next coordinate, then go to READ.
  - Bounds checks are done in 7-bit signed math; there is no wrap-around.
- READ (1 cycle): drive map_rd_x/y with the arm coordinate, then go to EVAL.
- EVAL (1 cycle): map_rd_data is valid this cycle.
  - WALL_CODE: no flame, no write; the arm ends. Advance direction, then go to STEP (or DONE after RIGHT).
  - BRICK_CODE: flame_valid=1; map_we=1 with map_wr_data=FLOOR_CODE at the coordinate; count++. The arm ends; advance as for a wall.
  - Any other code: flame_valid=1 and go to STEP to continue the arm.
- DONE (1 cycle): done=1; bricks_cleared=count; bricks_total += count (wraps). Go to IDLE.
- Cycle counts:
  - Each tile visited costs 3 cycles (STEP, READ, EVAL).
  - An arm ended by range or bounds costs 1 extra STEP cycle.
  - An arm ended by a wall or brick costs no extra cycle.
- Range 0: CENTER, then 4 terminating STEPs, then DONE (6 cycles after accept).
- map_rd_x/y hold their last value outside READ; map_we is high only in a brick EVAL.

Test Plan:
- All-floor map; blast (5,5) range 2 → 9 flame pulses in order: (5,5), (5,4), (5,3), (5,6), (5,7), (4,5), (3,5), (6,5), (7,5). done arrives 30 cycles after accept; bricks_cleared=0; map unchanged.
- Bricks at (5,3) and (7,5), wall at (5,6); blast (5,5) range 3:
  - UP flames (5,4) and (5,3); (5,3) is written to 10.
  - DOWN produces no flame.
  - LEFT flames (4,5), (3,5), (2,5).
  - RIGHT flames (6,5) and (7,5); (7,5) is written to 10.
  - bricks_cleared=2; bricks_total=2.
- Corner blast (0,0) range 3, all floor → UP and LEFT end at their first STEP. Flames: (0,0), (0,1), (0,2), (0,3), (1,0), (2,0), (3,0). No read ever goes out of range.
- Range 0 at (39,39) → single flame at (39,39); done 6 cycles after accept; map_we never high.
- Handshake and reset:
  - blast_valid held high during a blast is ignored; blast_ready=0 until DONE+1.
  - Reset_n low in the cycle after a brick write → idle next edge; all outputs 0; the written tile stays 10.
  - A new blast then completes normally.
